// File: rtl/bitstream_extractor_if.sv
// Byte-in / bits-out handshake bundle for the JPEG entropy-segment bit extractor.
interface bitstream_extractor_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        req_valid;
  logic [3:0]  req_len;
  logic        req_ready;
  logic        data_valid;
  logic [11:0] data_out;
  logic [3:0]  len_out;
  logic [5:0]  bits_avail;
  logic        marker_found;
  logic [7:0]  marker_code;
  logic        marker_clear;

  // Byte source / bit consumer side
  modport master (
    output byte_in, byte_valid, req_valid, req_len, marker_clear,
    input  byte_ready, req_ready, data_valid, data_out, len_out, bits_avail,
           marker_found, marker_code
  );

  // Extractor side
  modport slave (
    input  byte_in, byte_valid, req_valid, req_len, marker_clear,
    output byte_ready, req_ready, data_valid, data_out, len_out, bits_avail,
           marker_found, marker_code
  );
endinterface

// File: rtl/bitstream_extractor.sv
// Bit extractor for JPEG entropy-coded data: removes 0xFF00 stuffing and fill bytes,
// stops at markers, and hands out 0..12-bit fields from an MSB-aligned bit buffer.
module bitstream_extractor #(
  parameter int unsigned BUF_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bitstream_extractor_if.slave  bus
);

  typedef enum logic [1:0] {StNormal, StGotFf, StMarker} state_e;

  state_e           state_q;
  logic [BUF_W-1:0] bits_q, bits_d, shifted;
  logic [5:0]       count_q, count_d, cnt_after;
  logic             data_valid_q;
  logic [11:0]      data_out_q, data_d;
  logic [3:0]       len_out_q;
  logic             marker_found_q;
  logic [7:0]       marker_code_q;

  logic [3:0]       eff_len, consume;
  logic             byte_ready, req_ready, byte_acc, req_acc;
  logic             append;
  logic [7:0]       app_byte;

  assign eff_len    = (bus.req_len > 4'd12) ? 4'd12 : bus.req_len;
  assign byte_ready = (state_q != StMarker) && (count_q <= 6'd24);
  assign req_ready  = (count_q >= {2'b00, eff_len}) && !bus.marker_clear;
  assign byte_acc   = bus.byte_valid && byte_ready;
  assign req_acc    = bus.req_valid && req_ready;

  // Next buffer contents: consume from the top, then drop the new byte just below what remains
  always_comb begin
    append   = 1'b0;
    app_byte = bus.byte_in;
    if (byte_acc) begin
      case (state_q)
        StNormal: append = (bus.byte_in != 8'hFF);
        StGotFf: begin
          if (bus.byte_in == 8'h00) begin
            append   = 1'b1;
            app_byte = 8'hFF;
          end
        end
        default: append = 1'b0;
      endcase
    end
    consume   = req_acc ? eff_len : 4'd0;
    shifted   = bits_q << consume;
    cnt_after = count_q - {2'b00, consume};
    bits_d    = shifted;
    count_d   = cnt_after;
    if (append) begin
      // Bits below the valid region are always zero, so OR-ing in is safe
      bits_d  = shifted | ({app_byte, {(BUF_W-8){1'b0}}} >> cnt_after);
      count_d = cnt_after + 6'd8;
    end
    // Right-align the top eff_len bits; eff_len = 0 shifts everything out
    data_d = bits_q[BUF_W-1 -: 12] >> (4'd12 - eff_len);
  end

  // Stuffing/marker FSM, buffer state and registered output fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StNormal;
      bits_q         <= '0;
      count_q        <= '0;
      data_valid_q   <= 1'b0;
      data_out_q     <= '0;
      len_out_q      <= '0;
      marker_found_q <= 1'b0;
      marker_code_q  <= '0;
    end else if (bus.marker_clear) begin
      state_q        <= StNormal;
      bits_q         <= '0;
      count_q        <= '0;
      data_valid_q   <= 1'b0;
      marker_found_q <= 1'b0;
    end else begin
      bits_q       <= bits_d;
      count_q      <= count_d;
      data_valid_q <= req_acc;
      if (req_acc) begin
        data_out_q <= data_d;
        len_out_q  <= eff_len;
      end
      if (byte_acc) begin
        case (state_q)
          StNormal: if (bus.byte_in == 8'hFF) state_q <= StGotFf;
          StGotFf: begin
            if (bus.byte_in == 8'h00) begin
              state_q <= StNormal;
            end else if (bus.byte_in != 8'hFF) begin
              marker_code_q  <= bus.byte_in;
              marker_found_q <= 1'b1;
              state_q        <= StMarker;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign bus.byte_ready   = byte_ready;
  assign bus.req_ready    = req_ready;
  assign bus.data_valid   = data_valid_q;
  assign bus.data_out     = data_out_q;
  assign bus.len_out      = len_out_q;
  assign bus.bits_avail   = count_q;
  assign bus.marker_found = marker_found_q;
  assign bus.marker_code  = marker_code_q;

endmodule
